// File: rtl/digi_ota_array_if.sv
// Bus bundle for digi_ota_array: control, asynchronous comparator inputs
// and the registered per-channel pad drive outputs.
interface digi_ota_array_if #(
   parameter int NCH = 2
);
   logic           en;
   logic           mode;
   logic [NCH-1:0] clr;
   logic [NCH-1:0] vip;
   logic [NCH-1:0] vin;
   logic [NCH-1:0] out;
   logic [NCH-1:0] out_oe;
   logic [NCH-1:0] out_chg;

   modport master (
      output en, mode, clr, vip, vin,
      input  out, out_oe, out_chg
   );

   modport slave (
      input  en, mode, clr, vip, vin,
      output out, out_oe, out_chg
   );
endinterface

// File: rtl/digi_ota_array.sv
// Multi-channel clocked digital OTA: per channel a 2-flop synchroniser feeding
// either a hold-on-tie comparator (DIRECT) or a saturating hysteretic integrator.
module digi_ota_array #(
   parameter int NCH   = 2,
   parameter int CNT_W = 4,
   parameter int HYST  = 2
) (
   input  logic            clk,
   input  logic            rst,
   digi_ota_array_if.slave bus
);

   localparam logic [CNT_W-1:0] MID    = CNT_W'(2 ** (CNT_W - 1));
   localparam logic [CNT_W-1:0] SET_TH = CNT_W'(2 ** (CNT_W - 1) + HYST);
   localparam logic [CNT_W-1:0] CLR_TH = CNT_W'(2 ** (CNT_W - 1) - HYST);

   logic [NCH-1:0]   vip_p0, vin_p0, vip_p1, vin_p1;
   logic [CNT_W-1:0] cnt_p2 [NCH];
   logic [CNT_W-1:0] cnt_nx [NCH];
   logic [NCH-1:0]   out_p2, out_nx;
   logic [NCH-1:0]   oe_p2, oe_nx;
   logic [NCH-1:0]   vld_p2, vld_nx;
   logic [NCH-1:0]   chg_p2;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
      return (c == '0) ? c : c - CNT_W'(1);
   endfunction

   // Stage p0/p1: synchroniser, free-running regardless of en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vip_p0 <= '0;
         vin_p0 <= '0;
         vip_p1 <= '0;
         vin_p1 <= '0;
      end else begin
         vip_p0 <= bus.vip;
         vin_p0 <= bus.vin;
         vip_p1 <= vip_p0;
         vin_p1 <= vin_p0;
      end
   end

   // Stage p2 next-state: priority clr > en=0 > mode logic
   always_comb begin
      logic             up, dn;
      logic [CNT_W-1:0] c;
      for (int i = 0; i < NCH; i++) begin
         up        = vip_p1[i] & ~vin_p1[i];
         dn        = ~vip_p1[i] & vin_p1[i];
         c         = cnt_p2[i];
         cnt_nx[i] = cnt_p2[i];
         out_nx[i] = out_p2[i];
         vld_nx[i] = vld_p2[i];
         oe_nx[i]  = 1'b0;
         if (bus.clr[i]) begin
            cnt_nx[i] = MID;
            out_nx[i] = 1'b0;
            vld_nx[i] = 1'b0;
         end else if (bus.en) begin
            if (!bus.mode) begin
               if (up)      out_nx[i] = 1'b1;
               else if (dn) out_nx[i] = 1'b0;
               oe_nx[i] = up | dn;
            end else begin
               if (up)      c = sat_inc(cnt_p2[i]);
               else if (dn) c = sat_dec(cnt_p2[i]);
               cnt_nx[i] = c;
               if (c >= SET_TH) begin
                  out_nx[i] = 1'b1;
                  vld_nx[i] = 1'b1;
               end else if (c <= CLR_TH) begin
                  out_nx[i] = 1'b0;
                  vld_nx[i] = 1'b1;
               end
               oe_nx[i] = vld_nx[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) cnt_p2[i] <= MID;
         out_p2 <= '0;
         oe_p2  <= '0;
         vld_p2 <= '0;
         chg_p2 <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) cnt_p2[i] <= cnt_nx[i];
         out_p2 <= out_nx;
         oe_p2  <= oe_nx;
         vld_p2 <= vld_nx;
         chg_p2 <= out_nx ^ out_p2;
      end
   end

   assign bus.out     = out_p2;
   assign bus.out_oe  = oe_p2;
   assign bus.out_chg = chg_p2;

endmodule

// File: tb/tb_digi_ota_array.sv
// Directed bench for digi_ota_array (NCH=2, CNT_W=4, HYST=2: MID=8, set>=10, clear<=6).
module tb_digi_ota_array;

   localparam int NCH = 2;

   logic clk;
   logic rst;
   int   npass = 0;
   int   ntot  = 0;
   int   nchg;

   digi_ota_array_if #(.NCH(NCH)) bus ();

   digi_ota_array #(.NCH(NCH), .CNT_W(4), .HYST(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.en = 1'b0; bus.mode = 1'b0; bus.clr = '0; bus.vip = '0; bus.vin = '0;
      #1;
      chk("rst_out",  int'(bus.out),     0);
      chk("rst_oe",   int'(bus.out_oe),  0);
      chk("rst_chg",  int'(bus.out_chg), 0);
      chk("rst_cnt0", int'(dut.cnt_p2[0]), 8);
      ticks(2);
      chk("rst_hold_out", int'(bus.out), 0);
      #2 rst = 1'b0;
      bus.en = 1'b1; bus.mode = 1'b1;
      ticks(2);
      chk("idle_cnt0", int'(dut.cnt_p2[0]), 8);
      chk("idle_oe",   int'(bus.out_oe), 0);

      // Integrate up on ch0
      bus.vip = 2'b01; bus.vin = 2'b00;
      ticks(2);
      chk("lat_cnt0", int'(dut.cnt_p2[0]), 8);
      tick();
      chk("up1_cnt0", int'(dut.cnt_p2[0]), 9);
      chk("up1_out0", int'(bus.out[0]), 0);
      tick();
      chk("up2_cnt0", int'(dut.cnt_p2[0]), 10);
      chk("up2_out0", int'(bus.out[0]), 1);
      chk("up2_oe0",  int'(bus.out_oe[0]), 1);
      chk("up2_chg0", int'(bus.out_chg[0]), 1);
      chk("up2_out1", int'(bus.out[1]), 0);
      chk("up2_oe1",  int'(bus.out_oe[1]), 0);

      // Hysteresis going down
      bus.vip = 2'b00; bus.vin = 2'b01;
      tick();
      chk("up3_cnt0", int'(dut.cnt_p2[0]), 11);
      chk("up3_chg0", int'(bus.out_chg[0]), 0);
      tick();
      chk("up4_cnt0", int'(dut.cnt_p2[0]), 12);
      for (int e = 11; e >= 8; e--) begin
         tick();
         chk("dn_cnt0", int'(dut.cnt_p2[0]), e);
         chk("dn_out0", int'(bus.out[0]), 1);
      end
      bus.vip = 2'b01; bus.vin = 2'b01;
      tick();
      chk("dn7_cnt0", int'(dut.cnt_p2[0]), 7);
      chk("dn7_out0", int'(bus.out[0]), 1);
      tick();
      chk("dn6_cnt0", int'(dut.cnt_p2[0]), 6);
      chk("dn6_out0", int'(bus.out[0]), 0);
      chk("dn6_chg0", int'(bus.out_chg[0]), 1);
      chk("dn6_oe0",  int'(bus.out_oe[0]), 1);
      tick();
      chk("tie_cnt0", int'(dut.cnt_p2[0]), 6);
      chk("tie_chg0", int'(bus.out_chg[0]), 0);
      chk("tie_oe0",  int'(bus.out_oe[0]), 1);

      // Saturation both ends
      bus.vip = 2'b01; bus.vin = 2'b00;
      nchg = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         nchg += int'(bus.out_chg[0]);
      end
      chk("sat_hi_cnt0", int'(dut.cnt_p2[0]), 15);
      chk("sat_hi_out0", int'(bus.out[0]), 1);
      chk("sat_hi_nchg", nchg, 1);
      bus.vip = 2'b00; bus.vin = 2'b01;
      nchg = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         nchg += int'(bus.out_chg[0]);
      end
      chk("sat_lo_cnt0", int'(dut.cnt_p2[0]), 0);
      chk("sat_lo_out0", int'(bus.out[0]), 0);
      chk("sat_lo_oe0",  int'(bus.out_oe[0]), 1);
      chk("sat_lo_nchg", nchg, 1);

      // DIRECT mode on ch1: 10, 11, 01, 00
      bus.mode = 1'b0;
      bus.vip = 2'b10; bus.vin = 2'b01;
      tick();
      bus.vip = 2'b10; bus.vin = 2'b11;
      tick();
      bus.vip = 2'b00; bus.vin = 2'b11;
      tick();
      chk("dir0_out1", int'(bus.out[1]), 1);
      chk("dir0_oe1",  int'(bus.out_oe[1]), 1);
      bus.vip = 2'b00; bus.vin = 2'b01;
      tick();
      chk("dir1_out1", int'(bus.out[1]), 1);
      chk("dir1_oe1",  int'(bus.out_oe[1]), 0);
      tick();
      chk("dir2_out1", int'(bus.out[1]), 0);
      chk("dir2_oe1",  int'(bus.out_oe[1]), 1);
      tick();
      chk("dir3_out1", int'(bus.out[1]), 0);
      chk("dir3_oe1",  int'(bus.out_oe[1]), 0);
      chk("dir_cnt1",  int'(dut.cnt_p2[1]), 8);

      // Bring ch0 to cnt=12, out=1 for en/clr checks
      bus.mode = 1'b1;
      bus.vip = 2'b01; bus.vin = 2'b00;
      ticks(12);
      chk("ramp_cnt0", int'(dut.cnt_p2[0]), 10);
      bus.vip = 2'b01; bus.vin = 2'b01;
      ticks(2);
      chk("ramp_cnt0_12", int'(dut.cnt_p2[0]), 12);
      chk("ramp_out0",    int'(bus.out[0]), 1);
      chk("ramp_oe0",     int'(bus.out_oe[0]), 1);
      bus.en = 1'b0;
      tick();
      chk("en0_oe0",  int'(bus.out_oe[0]), 0);
      chk("en0_out0", int'(bus.out[0]), 1);
      ticks(2);
      chk("en0_cnt0", int'(dut.cnt_p2[0]), 12);
      chk("en0_oe0b", int'(bus.out_oe[0]), 0);
      chk("en0_chg0", int'(bus.out_chg[0]), 0);
      bus.en = 1'b1;
      tick();
      chk("en1_oe0", int'(bus.out_oe[0]), 1);
      bus.clr = 2'b01;
      tick();
      chk("clr_cnt0", int'(dut.cnt_p2[0]), 8);
      chk("clr_out0", int'(bus.out[0]), 0);
      chk("clr_oe0",  int'(bus.out_oe[0]), 0);
      chk("clr_chg0", int'(bus.out_chg[0]), 1);
      chk("clr_cnt1", int'(dut.cnt_p2[1]), 8);
      chk("clr_chg1", int'(bus.out_chg[1]), 0);
      bus.clr = 2'b00;
      tick();
      chk("clr_after_chg0", int'(bus.out_chg[0]), 0);
      chk("clr_after_oe0",  int'(bus.out_oe[0]), 0);

      // Async reset mid-operation
      bus.vip = 2'b01; bus.vin = 2'b00;
      ticks(5);
      bus.vip = 2'b01; bus.vin = 2'b01;
      ticks(2);
      chk("pre_rst_cnt0", int'(dut.cnt_p2[0]), 13);
      chk("pre_rst_out0", int'(bus.out[0]), 1);
      #3 rst = 1'b1;
      #1;
      chk("arst_out",  int'(bus.out), 0);
      chk("arst_oe",   int'(bus.out_oe), 0);
      chk("arst_cnt0", int'(dut.cnt_p2[0]), 8);
      #2 rst = 1'b0;
      ticks(2);
      bus.vip = 2'b01; bus.vin = 2'b00;
      ticks(2);
      chk("post_rst_lat_cnt0", int'(dut.cnt_p2[0]), 8);
      tick();
      chk("post_rst_up_cnt0", int'(dut.cnt_p2[0]), 9);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/digi_ota_array.md
Name: digi_ota_array

Overview:
- Multi-channel clocked successor to the gate-level digital OTA.
- Each channel compares a digital Vip/Vin pair after a 2-flop synchroniser.
- Two modes per block: DIRECT (registered comparator with hold-on-tie) and INTEGRATE (saturating up/down integrator with hysteresis thresholds).
- Drives per-channel out/out_oe pairs that feed the top-level analog/IO pad muxing, plus a one-cycle change strobe.

Parameters:
- NCH, 2, number of independent comparator channels (1..8).
- CNT_W, 4, integrator width; MID = 2^(CNT_W-1).
- HYST, 2, hysteresis half-width; valid range 1..MID-1.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  global enable; 0 freezes all state and forces out_oe=0.
- mode  input  1  0 = DIRECT, 1 = INTEGRATE; sampled every cycle.
- clr  input  NCH  synchronous per-channel clear.
- vip  input  NCH  per-channel positive input (asynchronous).
- vin  input  NCH  per-channel negative input (asynchronous).
- out  output  NCH  per-channel registered comparator decision.
- out_oe  output  NCH  per-channel drive enable (1 = decision valid, drive pad).
- out_chg  output  NCH  one-cycle pulse when out[i] toggles.

Behaviour:
- Reset (async, rst=1), all channels:
  - sync flops = 0, cnt = MID, out = 0, out_oe = 0, out_chg = 0, valid = 0.
  - Release takes effect on the next clk edge.
- Synchroniser: vip/vin pass through 2 flops (p_s, n_s). Synchronisers always run, even when en=0.
- Per-channel decision from synchronised values:
  - UP when p_s=1, n_s=0.
  - DN when p_s=0, n_s=1.
  - TIE when p_s = n_s.
- Priority per edge, per channel: rst > clr[i] > en=0 > mode logic.
  - clr[i]=1: cnt = MID, out = 0, out_oe = 0, valid = 0; out_chg pulses if out was 1.
  - en=0: cnt, out and valid hold; out_oe = 0 registered; out_chg = 0. When en returns to 1, out_oe recomputes on the next edge.
- DIRECT mode:
  - UP: out = 1. DN: out = 0. TIE: out holds.
  - out_oe = 1 on UP or DN, 0 on TIE (registered).
  - cnt frozen; valid unaffected.
- INTEGRATE mode:
  - UP: cnt+1, saturating at 2^CNT_W-1.
  - DN: cnt-1, saturating at 0.
  - TIE: cnt holds.
  - Thresholds use the post-update count cnt':
    - cnt' >= MID+HYST: out = 1, valid = 1.
    - cnt' <= MID-HYST: out = 0, valid = 1.
    - Otherwise out holds.
  - out_oe = valid.
- Mode switching: no side effects.
  - Switching to INTEGRATE resumes from the frozen cnt with current out/valid.
  - Switching to DIRECT uses the DIRECT out_oe rule immediately.
- out_chg[i] = 1 for exactly one cycle after any edge where out[i] changed value (clr included).
- Latency: an input change before edge E is in p_s/n_s after edge E+1. First cnt/out update from it is at edge E+2.
- Saturation: further UP at max (or DN at 0) leaves cnt unchanged, out unchanged, out_chg = 0.
- Channels are fully independent; simultaneous clr on one channel never affects others.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (NCH=2, CNT_W=4, HYST=2, so MID=8, set at >=10, clear at <=6):
- Reset then INTEGRATE, ch0 vip=1/vin=0 from edge E:
  - cnt 9 at E+2, 10 at E+3.
  - out[0]=1 and out_oe[0]=1 after E+3; out_chg[0] pulses for one cycle.
  - ch1 stays out=0, oe=0.
- Hysteresis, continuing with ch0 vip=0/vin=1:
  - cnt 9, 8, 7 → out stays 1.
  - cnt 6 → out=0, out_chg pulse.
  - Then TIE (1/1): cnt holds at 6, oe stays 1.
- Saturation:
  - 20 cycles of UP → cnt=15 with no further out_chg.
  - 20 cycles of DN → cnt=0, out=0.
- DIRECT mode ch1:
  - vip/vin sequence 10, 11, 01, 00 → out = 1, 1, 0, 0 and out_oe = 1, 0, 1, 0, each 2 edges after the input change.
- clr/en interaction, ch0 with out=1, cnt=12:
  - en=0 for 3 cycles → oe=0, cnt holds at 12; en=1 → oe=1 next edge.
  - clr[0] pulse → cnt=8, out=0, oe=0, out_chg[0]=1; ch1 unchanged.
- Async reset mid-operation:
  - Assert rst between edges while cnt=13, out=1 → all outputs 0 immediately, without waiting for a clock edge.
  - After release, cnt=8 and the first update lands 2 edges after the next input change.
